// File: rtl/rep_sequencer_if.sv
// Handshake bundle between decode, the REP sequencer and the downstream
// iteration consumer, plus the interrupt side-band.
interface rep_sequencer_if;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic        in_rep;
    logic [31:0] in_ecx;
    logic [63:0] in_info;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_info;
    logic        out_last;
    logic        ecx_wb_valid;
    logic [31:0] ecx_wb_data;
    logic        pending_int;
    logic        int_grant;
    logic        int_done;
    logic        busy;

    // Driver / environment side.
    modport master (
        output flush, in_valid, in_rep, in_ecx, in_info, out_ready, pending_int, int_done,
        input  in_ready, out_valid, out_info, out_last, ecx_wb_valid, ecx_wb_data,
               int_grant, busy
    );

    // Sequencer side.
    modport slave (
        input  flush, in_valid, in_rep, in_ecx, in_info, out_ready, pending_int, int_done,
        output in_ready, out_valid, out_info, out_last, ecx_wb_valid, ecx_wb_data,
               int_grant, busy
    );
endinterface

// File: rtl/rep_sequencer.sv
// REP-prefix sequencer: expands one accepted instruction into ECX iterations,
// writing back the decremented ECX after each one and pausing at iteration
// boundaries for pending interrupts.
module rep_sequencer (
    input  logic           clk,
    input  logic           reset,
    rep_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StPause = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] count_q, count_d;
    logic        rep_q, rep_d;
    logic [63:0] info_q, info_d;

    logic in_issue;
    logic accept;
    logic handshake;

    // Outputs decode from registered state; flush and pending_int gate them combinationally.
    assign in_issue         = (state_q == StIssue);
    assign bus.in_ready     = (state_q == StIdle) & ~bus.flush;
    assign bus.out_valid    = in_issue & ~bus.pending_int & ~bus.flush;
    assign bus.out_info     = info_q;
    assign bus.out_last     = in_issue & (count_q == 32'd1);
    assign bus.ecx_wb_valid = handshake & rep_q;
    assign bus.ecx_wb_data  = count_q - 32'd1;
    assign bus.int_grant    = (state_q == StPause);
    assign bus.busy         = (state_q != StIdle);

    assign accept    = bus.in_valid & bus.in_ready;
    assign handshake = bus.out_valid & bus.out_ready;

    // Next-state logic; flush overrides everything, including int_done and handshakes.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        rep_d   = rep_q;
        info_d  = info_q;
        if (bus.flush) begin
            state_d = StIdle;
            count_d = 32'd0;
            rep_d   = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        if (!bus.in_rep) begin
                            state_d = StIssue;
                            count_d = 32'd1;
                            rep_d   = 1'b0;
                            info_d  = bus.in_info;
                        end else if (bus.in_ecx != 32'd0) begin
                            state_d = StIssue;
                            count_d = bus.in_ecx;
                            rep_d   = 1'b1;
                            info_d  = bus.in_info;
                        end
                        // REP with ECX=0 is consumed with no iterations.
                    end
                end
                StIssue: begin
                    if (handshake) begin
                        count_d = count_q - 32'd1;
                        if (bus.out_last) begin
                            state_d = StIdle;
                        end
                    end else if (bus.pending_int) begin
                        state_d = StPause;
                    end
                end
                StPause: begin
                    if (bus.int_done) begin
                        state_d = StIssue;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            count_q <= 32'd0;
            rep_q   <= 1'b0;
            info_q  <= 64'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rep_q   <= rep_d;
            info_q  <= info_d;
        end
    end

endmodule

// File: tb/tb_rep_sequencer.sv
// Self-checking bench for rep_sequencer: a remaining-iterations model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_rep_sequencer;

    logic clk;
    logic reset;

    rep_sequencer_if bus ();

    rep_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Observed writeback data and out_last flags at each handshake.
    logic [31:0] wb_log[$];
    logic        last_log[$];

    // Model: iterations still owed; zero means nothing held.
    int unsigned m_rem    = 0;
    bit          m_paused = 1'b0;
    bit          m_rep    = 1'b0;
    logic [63:0] m_info   = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, then advance the model for the coming edge.
    always @(negedge clk) begin
        bit holding, e_in_ready, e_out_valid, e_last, e_grant, e_hs, e_wb;
        if (!reset) begin
            m_rem    = 0;
            m_paused = 1'b0;
            m_rep    = 1'b0;
            m_info   = '0;
            check("rst_out_valid", bus.out_valid, 0);
            check("rst_ecx_wb_valid", bus.ecx_wb_valid, 0);
            check("rst_int_grant", bus.int_grant, 0);
            check("rst_busy", bus.busy, 0);
            check("rst_out_last", bus.out_last, 0);
            check("rst_in_ready", bus.in_ready, {63'd0, ~bus.flush});
        end else begin
            holding     = (m_rem != 0);
            e_in_ready  = !holding && !bus.flush;
            e_out_valid = holding && !m_paused && !bus.pending_int && !bus.flush;
            e_last      = holding && !m_paused && (m_rem == 1);
            e_grant     = holding && m_paused;
            e_hs        = e_out_valid && bus.out_ready;
            e_wb        = e_hs && m_rep;
            check("in_ready", bus.in_ready, e_in_ready);
            check("out_valid", bus.out_valid, e_out_valid);
            check("int_grant", bus.int_grant, e_grant);
            check("busy", bus.busy, holding);
            check("ecx_wb_valid", bus.ecx_wb_valid, e_wb);
            if (holding && !m_paused) check("out_last", bus.out_last, e_last);
            if (e_out_valid) check("out_info", bus.out_info, m_info);
            if (e_wb) check("ecx_wb_data", bus.ecx_wb_data, 64'(m_rem - 1));
            if (bus.ecx_wb_valid) wb_log.push_back(bus.ecx_wb_data);
            if (bus.out_valid && bus.out_ready) last_log.push_back(bus.out_last);
            if (bus.flush) begin
                m_rem    = 0;
                m_paused = 1'b0;
                m_rep    = 1'b0;
            end else if (!holding) begin
                if (bus.in_valid && !bus.in_rep) begin
                    m_rem  = 1;
                    m_rep  = 1'b0;
                    m_info = bus.in_info;
                end else if (bus.in_valid && bus.in_ecx != 0) begin
                    m_rem  = bus.in_ecx;
                    m_rep  = 1'b1;
                    m_info = bus.in_info;
                end
            end else if (m_paused) begin
                if (bus.int_done) m_paused = 1'b0;
            end else if (e_hs) begin
                m_rem = m_rem - 1;
            end else if (bus.pending_int) begin
                m_paused = 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input bit rep, input logic [31:0] ecx, input logic [63:0] info);
        bus.in_valid = 1'b1;
        bus.in_rep   = rep;
        bus.in_ecx   = ecx;
        bus.in_info  = info;
        step();
        bus.in_valid = 1'b0;
        bus.in_rep   = 1'b0;
        bus.in_ecx   = '0;
        bus.in_info  = '0;
    endtask

    initial begin
        reset           = 1'b0;
        bus.flush       = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_rep      = 1'b0;
        bus.in_ecx      = '0;
        bus.in_info     = '0;
        bus.out_ready   = 1'b0;
        bus.pending_int = 1'b0;
        bus.int_done    = 1'b0;

        // Reset state.
        @(negedge clk);
        check("lit_rst_in_ready", bus.in_ready, 1);
        check("lit_rst_busy", bus.busy, 0);
        step();
        reset = 1'b1;
        step();

        // Single non-REP instruction.
        bus.out_ready = 1'b1;
        offer(1'b0, 32'd0, 64'hA5);
        @(negedge clk);
        check("lit_nrep_out_valid", bus.out_valid, 1);
        check("lit_nrep_out_last", bus.out_last, 1);
        check("lit_nrep_out_info", bus.out_info, 64'hA5);
        check("lit_nrep_wb", bus.ecx_wb_valid, 0);
        check("lit_nrep_busy", bus.busy, 1);
        step();
        @(negedge clk);
        check("lit_nrep_busy_after", bus.busy, 0);
        step();

        // REP ECX=3, downstream always ready.
        wb_log.delete();
        last_log.delete();
        offer(1'b1, 32'd3, 64'h1111);
        repeat (4) step();
        check("lit_rep3_wb_count", 64'(wb_log.size()), 3);
        if (wb_log.size() == 3) begin
            check("lit_rep3_wb0", wb_log[0], 2);
            check("lit_rep3_wb1", wb_log[1], 1);
            check("lit_rep3_wb2", wb_log[2], 0);
        end
        check("lit_rep3_hs_count", 64'(last_log.size()), 3);
        if (last_log.size() == 3) begin
            check("lit_rep3_last_pattern", {last_log[0], last_log[1], last_log[2]}, 3'b001);
        end
        check("lit_rep3_idle", bus.busy, 0);

        // REP ECX=0: consumed, nothing issued.
        wb_log.delete();
        bus.in_valid = 1'b1;
        bus.in_rep   = 1'b1;
        bus.in_ecx   = 32'd0;
        @(negedge clk);
        check("lit_rep0_in_ready", bus.in_ready, 1);
        step();
        bus.in_valid = 1'b0;
        bus.in_rep   = 1'b0;
        @(negedge clk);
        check("lit_rep0_busy", bus.busy, 0);
        check("lit_rep0_out_valid", bus.out_valid, 0);
        repeat (2) step();
        check("lit_rep0_no_wb", 64'(wb_log.size()), 0);

        // REP ECX=5 with an interrupt after the second iteration.
        wb_log.delete();
        offer(1'b1, 32'd5, 64'h5555);
        repeat (2) step();
        bus.pending_int = 1'b1;
        @(negedge clk);
        check("lit_int_out_valid_low", bus.out_valid, 0);
        step();
        @(negedge clk);
        check("lit_int_grant", bus.int_grant, 1);
        check("lit_int_busy", bus.busy, 1);
        step();
        bus.pending_int = 1'b0;
        bus.int_done    = 1'b1;
        @(negedge clk);
        check("lit_int_still_paused", bus.int_grant, 1);
        step();
        bus.int_done = 1'b0;
        repeat (4) step();
        check("lit_int_wb_count", 64'(wb_log.size()), 5);
        if (wb_log.size() == 5) begin
            check("lit_int_wb2", wb_log[2], 2);
            check("lit_int_wb3", wb_log[3], 1);
            check("lit_int_wb4", wb_log[4], 0);
        end

        // REP ECX=4 stalled downstream, then flushed.
        wb_log.delete();
        bus.out_ready = 1'b0;
        offer(1'b1, 32'd4, 64'h4444);
        @(negedge clk);
        check("lit_flush_pre_valid", bus.out_valid, 1);
        step();
        bus.flush = 1'b1;
        @(negedge clk);
        check("lit_flush_out_valid", bus.out_valid, 0);
        check("lit_flush_in_ready", bus.in_ready, 0);
        step();
        bus.flush = 1'b0;
        @(negedge clk);
        check("lit_flush_idle", bus.busy, 0);
        check("lit_flush_ready", bus.in_ready, 1);
        bus.out_ready = 1'b1;
        offer(1'b0, 32'd0, 64'h1234);
        @(negedge clk);
        check("lit_flush_next_info", bus.out_info, 64'h1234);
        step();
        check("lit_flush_no_wb", 64'(wb_log.size()), 0);

        // Flush while idle blocks acceptance.
        bus.flush = 1'b1;
        offer(1'b0, 32'd0, 64'hDEAD);
        bus.flush = 1'b0;
        @(negedge clk);
        check("lit_idle_flush_no_accept", bus.busy, 0);
        step();

        // Reset mid-ISSUE with count 7.
        wb_log.delete();
        bus.out_ready = 1'b0;
        offer(1'b1, 32'd7, 64'h7777);
        step();
        reset = 1'b0;
        #1;
        check("lit_rst_mid_out_valid", bus.out_valid, 0);
        check("lit_rst_mid_busy", bus.busy, 0);
        check("lit_rst_mid_count", bus.ecx_wb_data, 32'hFFFF_FFFF);
        bus.out_ready = 1'b1;
        repeat (3) step();
        check("lit_rst_mid_no_wb", 64'(wb_log.size()), 0);
        reset = 1'b1;
        step();
        offer(1'b0, 32'd0, 64'h77);
        @(negedge clk);
        check("lit_post_rst_info", bus.out_info, 64'h77);
        check("lit_post_rst_last", bus.out_last, 1);
        repeat (2) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rep_sequencer.md
REP_SEQUENCER -- requirements
Module: rep_sequencer

Interface
REQ-001 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset.
REQ-003 flush  input  1  pipeline flush; aborts any held instruction.
REQ-004 in_valid  input  1  decode offers an instruction.
REQ-005 in_ready  output  1  sequencer accepts the offered instruction.
REQ-006 in_rep  input  1  REP prefix present on offered instruction.
REQ-007 in_ecx  input  32  architectural ECX at offer time.
REQ-008 in_info  input  64  opaque instruction payload (decoded control bundle).
REQ-009 out_valid  output  1  one iteration offered downstream.
REQ-010 out_ready  input  1  downstream accepts the iteration.
REQ-011 out_info  output  64  latched payload for the current iteration.
REQ-012 out_last  output  1  current offered iteration is the final one.
REQ-013 ecx_wb_valid  output  1  ECX writeback strobe, register index fixed at 1, size 32-bit.
REQ-014 ecx_wb_data  output  32  new ECX value.
REQ-015 pending_int  input  1  external interrupt pending.
REQ-016 int_grant  output  1  interrupt may be serviced at this iteration boundary.
REQ-017 int_done  input  1  one-cycle pulse: interrupt handler entry complete.
REQ-018 busy  output  1  sequencer holds an instruction (state not IDLE).

Function
REQ-019 States: IDLE, ISSUE, PAUSE; state register 2 bits, count register 32 bits, rep flag 1 bit, info register 64 bits.
REQ-020 IDLE: in_ready = ~flush; out_valid = 0.
REQ-021 Accept (in_valid & in_ready) with in_rep=0: load count=1, rep=0, info=in_info; next state ISSUE.
REQ-022 Accept with in_rep=1 and in_ecx=0: instruction consumed, zero iterations, no writeback; state stays IDLE.
REQ-023 Accept with in_rep=1 and in_ecx!=0: load count=in_ecx, rep=1, info=in_info; next state ISSUE.
REQ-024 ISSUE: in_ready=0; out_valid = ~pending_int & ~flush; out_info = info register; out_last = (count==1).
REQ-025 Iteration handshake = out_valid & out_ready; on it count decrements by 1 (32-bit, no wrap possible since count>=1 in ISSUE).
REQ-026 On handshake with rep=1: ecx_wb_valid=1 same cycle, ecx_wb_data=count-1; with rep=0 ecx_wb_valid=0.
REQ-027 Handshake with out_last=1: next state IDLE; in_ready not asserted until the following cycle (no same-cycle re-accept).
REQ-028 ISSUE with pending_int=1 and flush=0: no handshake possible that cycle; next state PAUSE; count unchanged.
REQ-029 PAUSE: out_valid=0, in_ready=0, int_grant=1; on int_done next state ISSUE; pending_int ignored while in PAUSE.
REQ-030 int_grant=0 in IDLE and ISSUE; interrupt deferral in IDLE is the upstream's responsibility.
REQ-031 flush=1 in any state: next state IDLE, count=0, rep=0; out_valid, in_ready, ecx_wb_valid forced 0 that cycle; flush beats int_done and handshakes.
REQ-032 busy = (state != IDLE), registered-state derived, no combinational input dependence.
REQ-033 ecx_wb_data when ecx_wb_valid=0 is don't-care but driven as count-1.

Reset
REQ-034 reset low asynchronously forces state=IDLE, count=0, rep=0, info=0.
REQ-035 During and after reset: out_valid=0, ecx_wb_valid=0, int_grant=0, busy=0, out_last=0, in_ready=~flush.
REQ-036 Reset deassertion mid-operation: discarded instruction is not resumed; first post-reset accept behaves per REQ-021..023.

Verification
REQ-037 Non-REP: in_valid, in_rep=0, info=0xA5 -> one iteration next cycle, out_last=1, out_info=0xA5, no ecx_wb_valid, busy 1 cycle with out_ready=1.
REQ-038 REP ecx=3, out_ready=1 -> three handshakes on consecutive cycles, ecx_wb_data 2,1,0, out_last only on third, IDLE after.
REQ-039 REP ecx=0 -> accepted in one cycle, out_valid never asserted, no writeback, busy stays 0.
REQ-040 REP ecx=5, pending_int after second handshake -> PAUSE with int_grant=1, count=3; int_done -> resumes, writebacks 2,1,0.
REQ-041 REP ecx=4, out_ready=0 then flush -> out_valid drops same cycle, IDLE next cycle, no writeback; next accept works.
REQ-042 Assert reset low mid-ISSUE (count=7) -> immediate out_valid=0, busy=0, count=0, no further writebacks.
